wb_snoop_arbiter: RTL and testbench
===================================

Name: wb_snoop_arbiter

Overview:
- N-master to 1-slave Wishbone arbiter with a snoop-based coherence front end, placed between the per-core cache/bus masters and the shared memory slave.
- A granted read first polls all other cores over the snoop bus. A snoop hit returns the data straight from the owning core; a miss forwards the access to memory.
- A granted write broadcasts a write snoop (invalidate) and then passes through to memory.

Parameters:
- num_cores, 4, number of Wishbone masters / snooping cores
- aw, 32, address width
- dw, 32, data width

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- wbm_adr_i  in  num_cores*aw  master addresses; slot k = bits [k*aw +: aw]
- wbm_dat_i  in  num_cores*dw  master write data
- wbm_sel_i  in  num_cores*4  byte selects
- wbm_we_i  in  num_cores  write enables
- wbm_cyc_i  in  num_cores  cycle requests
- wbm_stb_i  in  num_cores  strobes
- wbm_cti_i  in  num_cores*3  cycle type
- wbm_bte_i  in  num_cores*2  burst type
- wbm_dat_o  out  num_cores*dw  read data, same value replicated in every slot
- wbm_ack_o  out  num_cores  ack, granted master only
- wbm_err_o  out  num_cores  error, granted master only
- wbm_rty_o  out  num_cores  retry, granted master only
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o  out  aw/dw/4/1/3/2  granted master's fields, muxed
- wbs_cyc_o  out  1  slave cycle
- wbs_stb_o  out  1  slave strobe
- wbs_dat_i  in  dw  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave error
- wbs_rty_i  in  1  slave retry
- snoop_adr_o  out  num_cores*aw  granted address, replicated in every slot
- snoop_type_o  out  2  snoop type: 00 IDLE, 01 READ, 10 WRITE, 11 unused
- snoop_response_i  in  num_cores*2  per-core poll answer: 11 hit, 00 miss, 10 pending
- snooped_dat_i  in  num_cores*dw  per-core data supplied on a hit

Behaviour:
- Registers:
  - state, one-hot: IDLE=0001, SNOOP_WRITE=0010, SNOOP_READ=0100, MEM_ACCESS=1000
  - master_sel, the granted index
  - rr_ptr, the round-robin pointer
- Reset (sync):
  - state=IDLE, master_sel=0, rr_ptr=0.
  - Outputs: snoop_type_o=00, wbs_cyc_o=0, wbs_stb_o=0, all wbm_ack/err/rty=0.
- Arbitration uses wbm_cyc_i only (stb ignored). Round-robin: search starts at rr_ptr, lowest index first after reset.
- IDLE: if any cyc is high, on the next edge latch master_sel and set rr_ptr=master_sel+1 (mod N).
  - we of the winner = 1 -> SNOOP_WRITE.
  - we of the winner = 0 -> SNOOP_READ.
- SNOOP_WRITE:
  - snoop_type_o=10 for exactly one cycle, then -> MEM_ACCESS.
- SNOOP_READ: snoop_type_o=01.
  - Every non-requester response field is evaluated; the requester's own field is ignored.
  - Any evaluated field not exactly 11 or 00 (10, 01, unknown) -> stay and wait.
  - All settled, at least one 11 = hit:
    - Source = lowest-index hitting core.
    - wbm_dat_o = snooped_dat_i of source, combinational.
    - wbm_ack_o[master_sel]=1 while the hit holds and wbm_cyc_i[master_sel]=1.
  - All settled, all 00 = miss -> MEM_ACCESS on the next edge.
  - Hit case: requester drops cyc -> IDLE.
- MEM_ACCESS: snoop_type_o=00.
  - wbs_cyc_o/wbs_stb_o = cyc/stb of master_sel.
  - wbm_ack/err/rty_o[master_sel] = wbs_ack/err/rty_i.
  - wbm_dat_o = wbs_dat_i in all slots.
  - Requester drops cyc -> IDLE (same edge; wbs_cyc_o falls combinationally).
- Requester drops cyc in any non-IDLE state -> IDLE, no ack.
- Always: wbs_adr/dat/sel/we/cti/bte = granted master's fields; snoop_adr_o = granted address, replicated.
- Outside SNOOP_READ and MEM_ACCESS: wbs_cyc_o=wbs_stb_o=0 and no acks.
- Non-granted masters never see ack/err/rty.
- Reset mid-transaction aborts to IDLE on the next edge.

Decomposition:
- Package wb_snoop_pkg holds:
  - state encodings;
  - snoop type codes: IDLE, READ, WRITE, NOT_USED;
  - response codes: POSITIVE=11, NEGATIVE=00, UNDEFINED=10.
- One sub-module: wb_rr_arbiter (round-robin grant from a cyc vector and pointer).

Test Plan:
- Reset, cyc=1111, we=0 -> master_sel=0, snoop_type_o=01 within 2 cycles. Responses held at 10 -> remains SNOOP_READ.
- Then snoop_response_i=0 -> state MEM_ACCESS, wbs_cyc_o=1. wbs_ack_i=1, wbs_dat_i=1 -> wbm_ack_o[0]=1, wbm_dat_o slot0=1. Drop cyc[0] -> IDLE.
- Reset, cyc=1110, response=8'h03, snooped_dat slot0=64 -> master_sel=1, wbm_dat_o[31:0]=64, wbm_ack_o[1]=1, wbs_cyc_o never asserted.
- Reset, cyc=1100, we[2]=1, dat slot2=55 -> snoop_type_o=10 for one cycle, then MEM_ACCESS with wbs_we_o=1, wbs_dat_o=55. wbs_ack_i=1 -> wbm_ack_o[2]=1.
- Back-to-back requests cyc=0011 with both masters held -> grants alternate 0,1,0 (round-robin).
- Assert wb_rst_i during MEM_ACCESS -> next edge IDLE, wbs_cyc_o=0, acks 0.

Source files
------------

// File: rtl/wb_snoop_arbiter_pkg.sv
// Shared encodings for the snooping Wishbone arbiter: controller states,
// snoop bus command codes and per-core snoop response codes.
package wb_snoop_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'b0001,
      ST_SNOOP_WRITE = 4'b0010,
      ST_SNOOP_READ  = 4'b0100,
      ST_MEM_ACCESS  = 4'b1000
   } state_t;

   typedef enum logic [1:0] {
      SNOOP_IDLE     = 2'b00,
      SNOOP_READ     = 2'b01,
      SNOOP_WRITE    = 2'b10,
      SNOOP_NOT_USED = 2'b11
   } snoop_type_t;

   localparam logic [1:0] RESP_POSITIVE  = 2'b11;
   localparam logic [1:0] RESP_NEGATIVE  = 2'b00;
   localparam logic [1:0] RESP_UNDEFINED = 2'b10;

endpackage

// File: rtl/wb_snoop_arbiter_rr.sv
// Round-robin grant: first requester found scanning upward from i_ptr,
// wrapping at num_cores.
module wb_rr_arbiter #(
   parameter int num_cores = 4,
   parameter int sw        = (num_cores > 1) ? $clog2(num_cores) : 1
) (
   input  logic [num_cores-1:0] i_req,
   input  logic [sw-1:0]        i_ptr,
   output logic [sw-1:0]        o_grant,
   output logic                 o_valid
);

   function automatic logic [sw-1:0] idx_of(input logic [sw-1:0] ptr, input int off);
      int s;
      s = int'(ptr) + off;
      if (s >= num_cores) s = s - num_cores;
      return sw'(s);
   endfunction

   // Scan from the far end so the closest requester to the pointer wins last.
   always_comb begin
      o_valid = 1'b0;
      o_grant = '0;
      for (int off = num_cores - 1; off >= 0; off--) begin
         if (i_req[idx_of(i_ptr, off)]) begin
            o_valid = 1'b1;
            o_grant = idx_of(i_ptr, off);
         end
      end
   end

endmodule

// File: rtl/wb_snoop_arbiter.sv
// N-master to 1-slave Wishbone arbiter; reads poll the other cores' caches
// first, writes broadcast an invalidate before going to memory.
module wb_snoop_arbiter
   import wb_snoop_pkg::*;
#(
   parameter int num_cores = 4,
   parameter int aw        = 32,
   parameter int dw        = 32
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [num_cores*aw-1:0] wbm_adr_i,
   input  logic [num_cores*dw-1:0] wbm_dat_i,
   input  logic [num_cores*4-1:0]  wbm_sel_i,
   input  logic [num_cores-1:0]    wbm_we_i,
   input  logic [num_cores-1:0]    wbm_cyc_i,
   input  logic [num_cores-1:0]    wbm_stb_i,
   input  logic [num_cores*3-1:0]  wbm_cti_i,
   input  logic [num_cores*2-1:0]  wbm_bte_i,
   output logic [num_cores*dw-1:0] wbm_dat_o,
   output logic [num_cores-1:0]    wbm_ack_o,
   output logic [num_cores-1:0]    wbm_err_o,
   output logic [num_cores-1:0]    wbm_rty_o,
   output logic [aw-1:0]           wbs_adr_o,
   output logic [dw-1:0]           wbs_dat_o,
   output logic [3:0]              wbs_sel_o,
   output logic                    wbs_we_o,
   output logic                    wbs_cyc_o,
   output logic                    wbs_stb_o,
   output logic [2:0]              wbs_cti_o,
   output logic [1:0]              wbs_bte_o,
   input  logic [dw-1:0]           wbs_dat_i,
   input  logic                    wbs_ack_i,
   input  logic                    wbs_err_i,
   input  logic                    wbs_rty_i,
   output logic [num_cores*aw-1:0] snoop_adr_o,
   output logic [1:0]              snoop_type_o,
   input  logic [num_cores*2-1:0]  snoop_response_i,
   input  logic [num_cores*dw-1:0] snooped_dat_i
);

   localparam int sw = (num_cores > 1) ? $clog2(num_cores) : 1;

   state_t                 r_state, w_next;
   logic [sw-1:0]          r_master_sel, r_rr_ptr, w_grant;
   logic                   w_grant_vld, w_req_cyc;
   logic                   w_hit, w_pending, w_ack, w_err, w_rty;
   logic [dw-1:0]          w_snoop_dat, w_rdat;
   logic [num_cores-1:0]   w_sel_onehot;

   wb_rr_arbiter #(.num_cores(num_cores), .sw(sw)) u_rr (
      .i_req   (wbm_cyc_i),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_valid (w_grant_vld)
   );

   assign w_req_cyc    = wbm_cyc_i[r_master_sel];
   assign w_sel_onehot = num_cores'(1) << r_master_sel;

   assign wbs_adr_o   = wbm_adr_i[int'(r_master_sel)*aw +: aw];
   assign wbs_dat_o   = wbm_dat_i[int'(r_master_sel)*dw +: dw];
   assign wbs_sel_o   = wbm_sel_i[int'(r_master_sel)*4 +: 4];
   assign wbs_we_o    = wbm_we_i[r_master_sel];
   assign wbs_cti_o   = wbm_cti_i[int'(r_master_sel)*3 +: 3];
   assign wbs_bte_o   = wbm_bte_i[int'(r_master_sel)*2 +: 2];
   assign snoop_adr_o = {num_cores{wbs_adr_o}};

   // Requester's own field is skipped; anything other than a clean hit/miss
   // (including X) holds the poll open.
   always_comb begin
      w_hit       = 1'b0;
      w_pending   = 1'b0;
      w_snoop_dat = '0;
      for (int k = num_cores - 1; k >= 0; k--) begin
         if (sw'(k) != r_master_sel) begin
            case (snoop_response_i[2*k +: 2])
               RESP_POSITIVE: begin
                  w_hit       = 1'b1;
                  w_snoop_dat = snooped_dat_i[k*dw +: dw];
               end
               RESP_NEGATIVE: ;
               RESP_UNDEFINED: w_pending = 1'b1;
               default:        w_pending = 1'b1;
            endcase
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      snoop_type_o = SNOOP_IDLE;
      wbs_cyc_o    = 1'b0;
      wbs_stb_o    = 1'b0;
      w_ack        = 1'b0;
      w_err        = 1'b0;
      w_rty        = 1'b0;
      w_rdat       = wbs_dat_i;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_vld)
               w_next = wbm_we_i[w_grant] ? ST_SNOOP_WRITE : ST_SNOOP_READ;
         end
         ST_SNOOP_WRITE: begin
            snoop_type_o = SNOOP_WRITE;
            w_next       = w_req_cyc ? ST_MEM_ACCESS : ST_IDLE;
         end
         ST_SNOOP_READ: begin
            snoop_type_o = SNOOP_READ;
            if (w_hit && !w_pending) begin
               w_rdat = w_snoop_dat;
               w_ack  = w_req_cyc;
            end
            if (!w_req_cyc)
               w_next = ST_IDLE;
            else if (!w_hit && !w_pending)
               w_next = ST_MEM_ACCESS;
         end
         ST_MEM_ACCESS: begin
            wbs_cyc_o = w_req_cyc;
            wbs_stb_o = wbm_stb_i[r_master_sel];
            w_ack     = wbs_ack_i;
            w_err     = wbs_err_i;
            w_rty     = wbs_rty_i;
            if (!w_req_cyc) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign wbm_dat_o = {num_cores{w_rdat}};
   assign wbm_ack_o = {num_cores{w_ack}} & w_sel_onehot;
   assign wbm_err_o = {num_cores{w_err}} & w_sel_onehot;
   assign wbm_rty_o = {num_cores{w_rty}} & w_sel_onehot;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state      <= ST_IDLE;
         r_master_sel <= '0;
         r_rr_ptr     <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_grant_vld) begin
            r_master_sel <= w_grant;
            r_rr_ptr     <= (w_grant == sw'(num_cores - 1)) ? '0 : w_grant + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_snoop_arbiter.sv
// Directed bench for wb_snoop_arbiter: a table of snoop-read decisions plus
// hand sequences for miss/memory, hit, write, round-robin and reset abort.
module tb_wb_snoop_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] wbm_adr, wbm_wdat, wbm_rdat, snp_adr, snp_dat;
   logic [15:0]  wbm_sel;
   logic [3:0]   wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err, wbm_rty;
   logic [11:0]  wbm_cti;
   logic [7:0]   wbm_bte, snp_resp;
   logic [31:0]  wbs_adr, wbs_wdat, wbs_rdat;
   logic [3:0]   wbs_sel;
   logic         wbs_we, wbs_cyc, wbs_stb, wbs_ack, wbs_err, wbs_rty;
   logic [2:0]   wbs_cti;
   logic [1:0]   wbs_bte, snp_type;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   wb_snoop_arbiter dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbm_adr_i(wbm_adr), .wbm_dat_i(wbm_wdat), .wbm_sel_i(wbm_sel),
      .wbm_we_i(wbm_we), .wbm_cyc_i(wbm_cyc), .wbm_stb_i(wbm_stb),
      .wbm_cti_i(wbm_cti), .wbm_bte_i(wbm_bte),
      .wbm_dat_o(wbm_rdat), .wbm_ack_o(wbm_ack), .wbm_err_o(wbm_err), .wbm_rty_o(wbm_rty),
      .wbs_adr_o(wbs_adr), .wbs_dat_o(wbs_wdat), .wbs_sel_o(wbs_sel), .wbs_we_o(wbs_we),
      .wbs_cyc_o(wbs_cyc), .wbs_stb_o(wbs_stb), .wbs_cti_o(wbs_cti), .wbs_bte_o(wbs_bte),
      .wbs_dat_i(wbs_rdat), .wbs_ack_i(wbs_ack), .wbs_err_i(wbs_err), .wbs_rty_i(wbs_rty),
      .snoop_adr_o(snp_adr), .snoop_type_o(snp_type),
      .snoop_response_i(snp_resp), .snooped_dat_i(snp_dat)
   );

   localparam int K_MISS = 0;
   localparam int K_HIT  = 1;
   localparam int K_WAIT = 2;

   typedef struct {
      int          req;
      logic [7:0]  resp;
      int          kind;
      logic [31:0] dat;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wbm_cyc  = '0;
      wbm_stb  = '0;
      wbm_we   = '0;
      snp_resp = '0;
      wbs_ack  = 1'b0;
      wbs_err  = 1'b0;
      wbs_rty  = 1'b0;
      wbs_rdat = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int   exp_g[3];
      logic bad;
      vec_t v;

      for (int k = 0; k < 4; k++) begin
         wbm_adr[k*32 +: 32]  = 32'(32'h1000 * (k + 1));
         wbm_wdat[k*32 +: 32] = 32'(50 + k);
         snp_dat[k*32 +: 32]  = 32'(100 + k);
      end
      wbm_sel = 16'hFFFF;
      wbm_cti = '0;
      wbm_bte = '0;

      //            req  response           kind    data
      vecs[0]  = '{0, 8'b00_00_00_00, K_MISS, 32'd0};
      vecs[1]  = '{0, 8'b11_00_00_00, K_HIT,  32'd103};
      vecs[2]  = '{0, 8'b11_00_11_00, K_HIT,  32'd101};
      vecs[3]  = '{1, 8'b00_00_00_11, K_HIT,  32'd100};
      vecs[4]  = '{1, 8'b00_00_11_00, K_MISS, 32'd0};
      vecs[5]  = '{2, 8'b00_10_00_00, K_MISS, 32'd0};
      vecs[6]  = '{2, 8'b10_00_00_11, K_WAIT, 32'd0};
      vecs[7]  = '{3, 8'b00_01_00_11, K_WAIT, 32'd0};
      vecs[8]  = '{3, 8'b01_00_11_00, K_HIT,  32'd101};
      vecs[9]  = '{3, 8'b11_11_11_11, K_HIT,  32'd100};
      vecs[10] = '{2, 8'b00_00_10_00, K_WAIT, 32'd0};

      // Reset state
      do_reset();
      @(negedge clk);
      chk("reset snoop_type", snp_type, 2'b00);
      chk("reset wbs_cyc", wbs_cyc, 1'b0);
      chk("reset wbs_stb", wbs_stb, 1'b0);
      chk("reset ack/err/rty", {wbm_ack, wbm_err, wbm_rty}, 12'h000);

      // Snoop-read decision table
      for (int i = 0; i < 11; i++) begin
         v = vecs[i];
         do_reset();
         wbm_cyc  = 4'(1 << v.req);
         wbm_stb  = wbm_cyc;
         snp_resp = v.resp;
         @(posedge clk); @(negedge clk);
         chk($sformatf("vec%0d snoop_type", i), snp_type, 2'b01);
         chk($sformatf("vec%0d ack", i), wbm_ack, (v.kind == K_HIT) ? wbm_cyc : 4'b0000);
         if (v.kind == K_HIT)
            chk($sformatf("vec%0d hit data", i), wbm_rdat, {4{v.dat}});
         @(posedge clk); @(negedge clk);
         chk($sformatf("vec%0d next wbs_cyc", i), wbs_cyc, (v.kind == K_MISS) ? 1'b1 : 1'b0);
         chk($sformatf("vec%0d next snoop_type", i), snp_type, (v.kind == K_MISS) ? 2'b00 : 2'b01);
      end

      // Read: pending poll, then miss to memory, ack, drop cyc
      do_reset();
      wbm_cyc  = 4'b1111;
      wbm_stb  = 4'b1111;
      snp_resp = 8'hAA;
      @(posedge clk); @(negedge clk);
      chk("A snoop_type read", snp_type, 2'b01);
      chk("A grant 0 adr", wbs_adr, 32'h1000);
      chk("A snoop_adr replicated", snp_adr, {4{32'h1000}});
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("A pending holds", snp_type, 2'b01);
      chk("A pending no wbs_cyc", wbs_cyc, 1'b0);
      snp_resp = 8'h00;
      @(posedge clk); @(negedge clk);
      chk("A mem snoop_type", snp_type, 2'b00);
      chk("A mem wbs_cyc", wbs_cyc, 1'b1);
      chk("A mem wbs_stb", wbs_stb, 1'b1);
      wbs_ack  = 1'b1;
      wbs_rdat = 32'd1;
      #1;
      chk("A mem ack", wbm_ack, 4'b0001);
      chk("A mem data", wbm_rdat, {4{32'd1}});
      wbm_cyc = 4'b1110;
      #1;
      chk("A drop wbs_cyc", wbs_cyc, 1'b0);
      wbs_ack = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("A next grant snoop", snp_type, 2'b01);
      chk("A next grant adr", wbs_adr, 32'h2000);

      // Read hit from core 0 for requester 1
      do_reset();
      wbm_cyc  = 4'b1110;
      wbm_stb  = 4'b1110;
      snp_resp = 8'h03;
      snp_dat[31:0] = 32'd64;
      @(posedge clk); @(negedge clk);
      chk("B hit ack", wbm_ack, 4'b0010);
      chk("B hit data", wbm_rdat[31:0], 32'd64);
      bad = wbs_cyc;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         if (wbs_cyc) bad = 1'b1;
      end
      chk("B wbs_cyc never", bad, 1'b0);
      chk("B hit ack held", wbm_ack, 4'b0010);
      wbm_cyc = 4'b1100;
      #1;
      chk("B drop ack", wbm_ack, 4'b0000);
      snp_dat[31:0] = 32'd100;

      // Write: one-cycle invalidate, then memory pass-through
      do_reset();
      wbm_cyc  = 4'b1100;
      wbm_stb  = 4'b1100;
      wbm_we   = 4'b0100;
      wbm_wdat[64 +: 32] = 32'd55;
      @(posedge clk); @(negedge clk);
      chk("C snoop write", snp_type, 2'b10);
      chk("C write no wbs_cyc", wbs_cyc, 1'b0);
      chk("C grant 2 adr", wbs_adr, 32'h3000);
      @(posedge clk); @(negedge clk);
      chk("C mem snoop_type", snp_type, 2'b00);
      chk("C mem wbs_cyc", wbs_cyc, 1'b1);
      chk("C wbs_we", wbs_we, 1'b1);
      chk("C wbs_dat", wbs_wdat, 32'd55);
      wbs_ack = 1'b1;
      #1 chk("C ack", wbm_ack, 4'b0100);
      wbs_ack = 1'b0;
      wbs_err = 1'b1;
      #1 chk("C err", {wbm_err, wbm_ack}, 8'h40);
      wbs_err = 1'b0;
      wbs_rty = 1'b1;
      #1 chk("C rty", {wbm_rty, wbm_err}, 8'h40);
      wbs_rty = 1'b0;
      wbm_we  = 4'b0000;
      wbm_wdat[64 +: 32] = 32'd52;

      // Round-robin between two persistent requesters
      do_reset();
      wbm_cyc = 4'b0011;
      wbm_stb = 4'b0011;
      exp_g   = '{0, 1, 0};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("D grant%0d adr", i), wbs_adr, 32'(32'h1000 * (exp_g[i] + 1)));
         chk($sformatf("D grant%0d snoop", i), snp_type, 2'b01);
         wbm_cyc[exp_g[i]] = 1'b0;
         @(posedge clk);
         #1 wbm_cyc = 4'b0011;
      end

      // Reset during memory access
      do_reset();
      wbm_cyc = 4'b0001;
      wbm_stb = 4'b0001;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("E mem wbs_cyc", wbs_cyc, 1'b1);
      wbs_ack = 1'b1;
      #1 chk("E mem ack", wbm_ack, 4'b0001);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("E rst wbs_cyc", wbs_cyc, 1'b0);
      chk("E rst ack", wbm_ack, 4'b0000);
      chk("E rst snoop_type", snp_type, 2'b00);
      @(posedge clk); @(negedge clk);
      chk("E rst held idle", {snp_type, wbs_cyc}, 3'b000);
      rst     = 1'b0;
      wbs_ack = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
